// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, LSB first, one bit per clock
// through a single full-subtractor cell with a registered borrow.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; diff/borrow_out hold the last result
// SHIFT | processing one bit per edge; done pulses on the last bit
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_bo;
    logic w_last;

    // Single full-subtractor cell fed from the shift-register LSBs.
    assign w_x    = r_a[0];
    assign w_y    = r_b[0];
    assign w_d    = w_x ^ w_y ^ r_borrow;
    assign w_bo   = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);
    assign w_last = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= borrow_in;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    // New bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_borrow_out <= w_bo;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Bench for serial_full_subtractor: WIDTH=8 directed cases and WIDTH=4 exhaustive,
// checked every cycle against an arithmetic reference model.
module tb_serial_full_subtractor;

    logic clk;
    logic rst_n;

    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic       bin_s   [2];

    logic       busy8, done8, bo8;
    logic [7:0] diff8;
    logic       busy4, done4, bo4;
    logic [3:0] diff4;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state, per unit (0 = WIDTH 8, 1 = WIDTH 4)
    int m_left [2];
    bit m_busy [2];
    bit m_done [2];
    int m_diff [2];
    bit m_bo   [2];
    int p_diff [2];
    bit p_bo   [2];

    serial_full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[0]),
        .a          (a_s[0]),
        .b          (b_s[0]),
        .borrow_in  (bin_s[0]),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8)
    );

    serial_full_subtractor #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[1]),
        .a          (a_s[1][3:0]),
        .b          (b_s[1][3:0]),
        .borrow_in  (bin_s[1]),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (bo4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a start seen while idle yields the arithmetic result WIDTH edges later.
    always @(posedge clk or negedge rst_n) begin
        int r;
        int wid;
        int mask;
        for (int u = 0; u < 2; u++) begin
            wid  = (u == 0) ? 8 : 4;
            mask = (1 << wid) - 1;
            if (!rst_n) begin
                m_left[u] = 0;
                m_busy[u] = 0;
                m_done[u] = 0;
                m_diff[u] = 0;
                m_bo[u]   = 0;
            end else begin
                m_done[u] = 0;
                if (m_left[u] > 0) begin
                    m_left[u]--;
                    if (m_left[u] == 0) begin
                        m_done[u] = 1;
                        m_busy[u] = 0;
                        m_diff[u] = p_diff[u];
                        m_bo[u]   = p_bo[u];
                    end
                end else if (start_s[u]) begin
                    r = (int'(a_s[u]) & mask) - (int'(b_s[u]) & mask) - int'(bin_s[u]);
                    p_diff[u] = r & mask;
                    p_bo[u]   = (r < 0);
                    m_left[u] = wid;
                    m_busy[u] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy8", 32'(busy8), 32'(m_busy[0]));
            chk("done8", 32'(done8), 32'(m_done[0]));
            chk("busy4", 32'(busy4), 32'(m_busy[1]));
            chk("done4", 32'(done4), 32'(m_done[1]));
            if (!m_busy[0]) begin
                chk("diff8", 32'(diff8), m_diff[0]);
                chk("bo8",   32'(bo8),   32'(m_bo[0]));
            end
            if (!m_busy[1]) begin
                chk("diff4", 32'(diff4), m_diff[1]);
                chk("bo4",   32'(bo4),   32'(m_bo[1]));
            end
        end
    end

    // Waits from the negedge after the accepting edge until done is seen; returns edges elapsed.
    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input int exp_diff, input int exp_bo, input string nm);
        int n;
        @(negedge clk);
        a_s[0] = a; b_s[0] = b; bin_s[0] = bin; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk({nm, "_busy"}, 32'(busy8), 1);
        wait_done8(n);
        chk({nm, "_lat"}, n, 8);
        chk({nm, "_diff"}, 32'(diff8), exp_diff);
        chk({nm, "_bo"}, 32'(bo8), exp_bo);
    endtask

    initial begin
        int n;
        int r;
        int done_seen;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; a_s[u] = '0; b_s[u] = '0; bin_s[u] = 1'b0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_diff", 32'(diff8), 0);
        chk("rst_bo",   32'(bo8),   0);
        chk_en = 1;
        rst_n  = 1'b1;
        @(negedge clk);

        op8(8'd100, 8'd37, 1'b0, 63, 0, "d100_37");
        op8(8'h00, 8'h01, 1'b0, 255, 1, "d00_01");
        op8(8'h55, 8'h55, 1'b1, 255, 1, "d55_55_b1");
        op8(8'h55, 8'h55, 1'b0, 0, 0, "d55_55_b0");
        op8(8'hFF, 8'h00, 1'b1, 254, 0, "dFF_00_b1");

        // start held with fresh operands during busy, then back-to-back from the done cycle
        @(negedge clk);
        a_s[0] = 8'd20; b_s[0] = 8'd30; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        a_s[0] = 8'd1; b_s[0] = 8'd1; bin_s[0] = 1'b1;
        wait_done8(n);
        chk("held_lat", n, 8);
        chk("held_diff", 32'(diff8), 246);
        chk("held_bo", 32'(bo8), 1);
        a_s[0] = 8'd200; b_s[0] = 8'd50; bin_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("b2b_busy", 32'(busy8), 1);
        chk("b2b_done_fell", 32'(done8), 0);
        wait_done8(n);
        chk("b2b_lat", n, 8);
        chk("b2b_diff", 32'(diff8), 150);
        chk("b2b_bo", 32'(bo8), 0);

        // reset at edge k+4 of an operation
        @(negedge clk);
        a_s[0] = 8'd250; b_s[0] = 8'd5; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy8), 0);
        chk("mid_rst_done", 32'(done8), 0);
        chk("mid_rst_diff", 32'(diff8), 0);
        chk("mid_rst_bo",   32'(bo8),   0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        chk("mid_rst_no_done", done_seen, 0);
        op8(8'd9, 8'd3, 1'b0, 6, 0, "d9_3");

        // WIDTH=4 exhaustive, back-to-back; case i -> a=i[8:5], b=i[4:1], borrow_in=i[0]
        @(negedge clk);
        a_s[1] = 8'd0; b_s[1] = 8'd0; bin_s[1] = 1'b0; start_s[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            r = ((i >> 5) & 15) - ((i >> 1) & 15) - (i & 1);
            if (i < 511) begin
                a_s[1]  = 8'(((i + 1) >> 5) & 15);
                b_s[1]  = 8'(((i + 1) >> 1) & 15);
                bin_s[1] = 1'((i + 1) & 1);
            end else begin
                start_s[1] = 1'b0;
            end
            n = 0;
            while (!done4 && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("ex4_lat", n, 4);
            chk("ex4_diff", 32'(diff4), r & 15);
            chk("ex4_bo", 32'(bo4), (r < 0) ? 1 : 0);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
